// File: rtl/operand_feeder.sv
// operand_feeder: reads K columns from eight row banks (memA rows 0..3, memB
// rows 0..3) and feeds them as a diagonally skewed operand stream into the
// west and north edges of a 4x4 systolic array. Lane r is delayed r cycles
// relative to lane 0. Slots that carry no real element are driven to zero.
// Optional build macro FEEDER_PERF_EN adds a saturating busy-cycle counter
// on port perf_cycles.
module operand_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        ap_start,
  input  logic [4:0]  len,
  input  logic [7:0]  base_col,
  output logic        rd_en,
  output logic [7:0]  rd_col,
  input  logic [15:0] a_row0,
  input  logic [15:0] a_row1,
  input  logic [15:0] a_row2,
  input  logic [15:0] a_row3,
  input  logic [15:0] b_row0,
  input  logic [15:0] b_row1,
  input  logic [15:0] b_row2,
  input  logic [15:0] b_row3,
  output logic [15:0] a_out0,
  output logic [15:0] a_out1,
  output logic [15:0] a_out2,
  output logic [15:0] a_out3,
  output logic [15:0] b_out0,
  output logic [15:0] b_out1,
  output logic [15:0] b_out2,
  output logic [15:0] b_out3,
  output logic        valid_out,
  output logic        busy,
  output logic        done
`ifdef FEEDER_PERF_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  // The last element leaves lane 3 five cycles after its read cycle.
  localparam logic [4:0] DRAIN_LAST = 5'd4;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  len_q, len_d;
  logic [7:0]  base_q, base_d;
  // rd_hist_q[k] is rd_en delayed by k+1 cycles; bit 0 marks bank data valid.
  logic [4:0]  rd_hist_q;
  logic        start_acc;

  assign start_acc = (state_q == S_IDLE) && ap_start;

  // Next-state and counter logic for the read/drain sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d   = len;
          base_d  = base_col;
          cnt_d   = '0;
          state_d = (len == 5'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == len_q - 5'd1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, latched instruction fields and read-strobe history.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      rd_hist_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      rd_hist_q <= {rd_hist_q[3:0], rd_en};
    end
  end

  assign rd_en     = (state_q == S_READ);
  assign rd_col    = base_q + {3'b000, cnt_q};  // wraps modulo 256
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign valid_out = |rd_hist_q[4:1];

  logic [15:0] a_in [4];
  logic [15:0] b_in [4];
  logic [15:0] a_lane [4];
  logic [15:0] b_lane [4];

  assign a_in[0] = a_row0;
  assign a_in[1] = a_row1;
  assign a_in[2] = a_row2;
  assign a_in[3] = a_row3;
  assign b_in[0] = b_row0;
  assign b_in[1] = b_row1;
  assign b_in[2] = b_row2;
  assign b_in[3] = b_row3;

  for (genvar r = 0; r < 4; r++) begin : g_lane
    logic [15:0] a_sr_q [0:r];
    logic [15:0] b_sr_q [0:r];

    // Capture bank data only when a read was issued, then delay lane r by r cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: the skew arrays are reset element by element; stale operands must not leak into the array.
        for (int k = 0; k <= r; k++) begin
          a_sr_q[k] <= '0;
          b_sr_q[k] <= '0;
        end
      end else begin
        a_sr_q[0] <= rd_hist_q[0] ? a_in[r] : 16'd0;
        b_sr_q[0] <= rd_hist_q[0] ? b_in[r] : 16'd0;
        for (int k = 1; k <= r; k++) begin
          a_sr_q[k] <= a_sr_q[k-1];
          b_sr_q[k] <= b_sr_q[k-1];
        end
      end
    end

    assign a_lane[r] = a_sr_q[r];
    assign b_lane[r] = b_sr_q[r];
  end

  assign a_out0 = a_lane[0];
  assign a_out1 = a_lane[1];
  assign a_out2 = a_lane[2];
  assign a_out3 = a_lane[3];
  assign b_out0 = b_lane[0];
  assign b_out1 = b_lane[1];
  assign b_out2 = b_lane[2];
  assign b_out3 = b_lane[3];

`ifdef FEEDER_PERF_EN
  logic [15:0] perf_q;

  // Busy-cycle counter: cleared on accepted start, saturates, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: directed table-driven bench for operand_feeder with a
// one-cycle-latency row-bank model that drives junk when no read was issued.
module tb_operand_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ap_start;
  logic [4:0]  len;
  logic [7:0]  base_col;
  logic        rd_en;
  logic [7:0]  rd_col;
  logic [15:0] a_row0, a_row1, a_row2, a_row3;
  logic [15:0] b_row0, b_row1, b_row2, b_row3;
  logic [15:0] a_out0, a_out1, a_out2, a_out3;
  logic [15:0] b_out0, b_out1, b_out2, b_out3;
  logic        valid_out, busy, done;
`ifdef FEEDER_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_feeder dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .len(len), .base_col(base_col),
    .rd_en(rd_en), .rd_col(rd_col),
    .a_row0(a_row0), .a_row1(a_row1), .a_row2(a_row2), .a_row3(a_row3),
    .b_row0(b_row0), .b_row1(b_row1), .b_row2(b_row2), .b_row3(b_row3),
    .a_out0(a_out0), .a_out1(a_out1), .a_out2(a_out2), .a_out3(a_out3),
    .b_out0(b_out0), .b_out1(b_out1), .b_out2(b_out2), .b_out3(b_out3),
    .valid_out(valid_out), .busy(busy), .done(done)
`ifdef FEEDER_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Row-bank model: A row r column c holds 10*r+c, B holds 1000+100*r+c.
  logic       mem_en_q = 1'b0;
  logic [7:0] mem_col_q = 8'd0;
  always @(posedge clk) begin
    mem_en_q  <= rd_en;
    mem_col_q <= rd_col;
  end

  function automatic logic [15:0] a_val(input int r, input logic [7:0] c);
    return 16'(10 * r + int'(c));
  endfunction
  function automatic logic [15:0] b_val(input int r, input logic [7:0] c);
    return 16'(1000 + 100 * r + int'(c));
  endfunction

  assign a_row0 = mem_en_q ? a_val(0, mem_col_q) : 16'hDEAD;
  assign a_row1 = mem_en_q ? a_val(1, mem_col_q) : 16'hBEEF;
  assign a_row2 = mem_en_q ? a_val(2, mem_col_q) : 16'hCAFE;
  assign a_row3 = mem_en_q ? a_val(3, mem_col_q) : 16'hF00D;
  assign b_row0 = mem_en_q ? b_val(0, mem_col_q) : 16'h1234;
  assign b_row1 = mem_en_q ? b_val(1, mem_col_q) : 16'h5678;
  assign b_row2 = mem_en_q ? b_val(2, mem_col_q) : 16'h9ABC;
  assign b_row3 = mem_en_q ? b_val(3, mem_col_q) : 16'hDEF0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    logic        start;
    logic        en;
    logic [7:0]  col;
    logic        valid;
    logic        bsy;
    logic        dn;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] b0;
    logic [15:0] b3;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // L=4, base_col=0 run, cycle 0 is the start cycle.
    tbl[0]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0,  16'd0,    16'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0,    16'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0,    16'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0,  16'd1000, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 16'd10, 16'd0,  16'd1001, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd11, 16'd20, 16'd1002, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd12, 16'd21, 16'd1003, 16'd1300};
    tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd13, 16'd22, 16'd0,    16'd1301};
    tbl[8]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd23, 16'd0,    16'd1302};
    tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0,    16'd1303};
    tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 16'd0,  16'd0,  16'd0,    16'd0};
    tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0,  16'd0,    16'd0};

    // Reset, with a start request coincident with reset that must be dropped.
    rst = 1'b1; ap_start = 1'b1; len = 5'd4; base_col = 8'd7;
    repeat (3) @(negedge clk);
    check("rst_rd_en", 0, rd_en, 0);
    check("rst_rd_col", 0, rd_col, 0);
    check("rst_valid", 0, valid_out, 0);
    check("rst_busy", 0, busy, 0);
    check("rst_done", 0, done, 0);
    check("rst_a_out3", 0, a_out3, 0);
    check("rst_b_out3", 0, b_out3, 0);
    rst = 1'b0; ap_start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 0, busy, 0);

    // Main table-driven run: L=4, base 0.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      ap_start = tbl[k].start; len = 5'd4; base_col = 8'd0;
      check("t_rd_en", k, rd_en, tbl[k].en);
      if (tbl[k].en) check("t_rd_col", k, rd_col, tbl[k].col);
      check("t_valid", k, valid_out, tbl[k].valid);
      check("t_busy", k, busy, tbl[k].bsy);
      check("t_done", k, done, tbl[k].dn);
      check("t_a_out1", k, a_out1, tbl[k].a1);
      check("t_a_out2", k, a_out2, tbl[k].a2);
      check("t_b_out0", k, b_out0, tbl[k].b0);
      check("t_b_out3", k, b_out3, tbl[k].b3);
`ifdef FEEDER_PERF_EN
      if (k >= 10) check("t_perf", k, perf_cycles, 9);
`endif
    end
    repeat (3) @(negedge clk);
`ifdef FEEDER_PERF_EN
    check("perf_hold", 14, perf_cycles, 9);
`endif

    // L=3 starting at column 254: column address wraps 254,255,0.
    begin
      logic [7:0]  exp_col [3];
      logic [15:0] exp_b0 [3];
      exp_col[0] = 8'd254; exp_col[1] = 8'd255; exp_col[2] = 8'd0;
      exp_b0[0] = 16'd1254; exp_b0[1] = 16'd1255; exp_b0[2] = 16'd1000;
      for (int k = 0; k <= 10; k++) begin
        if (k > 0) @(negedge clk);
        ap_start = (k == 0); len = 5'd3; base_col = 8'd254;
        check("w_rd_en", k, rd_en, (k >= 1 && k <= 3));
        if (k >= 1 && k <= 3) check("w_rd_col", k, rd_col, exp_col[k-1]);
        if (k >= 3 && k <= 5) check("w_b_out0", k, b_out0, exp_b0[k-3]);
        check("w_done", k, done, (k == 9));
      end
    end

    // L=0: no reads, no window, done at cycle 1, idle at cycle 2.
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      ap_start = (k == 0); len = 5'd0; base_col = 8'd40;
      check("z_rd_en", k, rd_en, 0);
      check("z_valid", k, valid_out, 0);
      check("z_busy", k, busy, 0);
      check("z_done", k, done, (k == 1));
    end

    // L=5 base 10, ignored re-start at cycle 2, back-to-back L=1 base 50 at cycle 12.
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      ap_start = (k == 0 || k == 2 || k == 12);
      if (k == 0)       begin len = 5'd5; base_col = 8'd10; end
      else if (k == 2)  begin len = 5'd7; base_col = 8'd99; end
      else if (k == 12) begin len = 5'd1; base_col = 8'd50; end
      check("r_rd_en", k, rd_en, ((k >= 1 && k <= 5) || k == 13));
      if (k >= 1 && k <= 5) check("r_rd_col", k, rd_col, 10 + k - 1);
      if (k == 13) check("r_rd_col2", k, rd_col, 50);
      check("r_busy", k, busy, ((k >= 1 && k <= 10) || (k >= 13 && k <= 18)));
      check("r_done", k, done, (k == 11 || k == 19));
    end
    repeat (2) @(negedge clk);

    // L=8 run interrupted by reset at cycle 4: all outputs clear, no done.
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge clk);
      ap_start = (k == 0 || k == 4); len = 5'd8; base_col = 8'd0;
      rst = (k == 4);
      if (k == 4) check("x_b_out0_pre", k, b_out0, 1001);
      if (k == 5) begin
        check("x_rd_en", k, rd_en, 0);
        check("x_rd_col", k, rd_col, 0);
        check("x_valid", k, valid_out, 0);
        check("x_busy", k, busy, 0);
        check("x_a_out0", k, a_out0, 0);
        check("x_a_out1", k, a_out1, 0);
        check("x_b_out0", k, b_out0, 0);
        check("x_b_out2", k, b_out2, 0);
      end
      if (k >= 5) check("x_done", k, done, 0);
      if (k >= 6) check("x_idle", k, busy, 0);
    end
    rst = 1'b0;

    // Fresh L=2 run after the interrupted one.
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      ap_start = (k == 0); len = 5'd2; base_col = 8'd3;
      check("f_valid", k, valid_out, (k >= 3 && k <= 7));
      check("f_done", k, done, (k == 8));
      if (k == 3) check("f_a_out0", k, a_out0, 3);
      if (k == 7) check("f_b_out3", k, b_out3, 1304);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ap_start  input  1  one-cycle start request; honoured only in IDLE.
REQ-004 len  input  5  inner dimension K of the current instruction; sampled with ap_start.
REQ-005 base_col  input  8  first column of the operand slice in each row bank; sampled with ap_start.
REQ-006 rd_en  output  1  read strobe to memA/memB row banks.
REQ-007 rd_col  output  8  column address, common to all 8 banks (bank address = 256*row + rd_col).
REQ-008 a_row0..a_row3  input  16 each  memA row-bank read data; valid 1 cycle after rd_en.
REQ-009 b_row0..b_row3  input  16 each  memB row-bank read data; valid 1 cycle after rd_en.
REQ-010 a_out0..a_out3  output  16 each  skewed west-edge operands to the 4x4 systolic array.
REQ-011 b_out0..b_out3  output  16 each  skewed north-edge operands to the 4x4 systolic array.
REQ-012 valid_out  output  1  high for every cycle of the skewed stream window.
REQ-013 busy  output  1  high from the cycle after an accepted start through the last window cycle.
REQ-014 done  output  1  one-cycle pulse after the window ends.

Function
REQ-015 FSM states: IDLE, READ, DRAIN, DONE; only IDLE accepts ap_start.
REQ-016 Start sampled at cycle 0 with len=L>0: READ occupies cycles 1..L with rd_en=1, rd_col=base_col+j at cycle j+1, j=0..L-1.
REQ-017 rd_col arithmetic is modulo 256; base_col+j wraps from 255 to 0 without error.
REQ-018 Bank data for column j is registered at cycle j+2; lane r (0..3) drives row r / column r element j at cycle j+3+r (skew r cycles, registered outputs).
REQ-019 Any lane cycle not carrying a real element drives 16'd0 on both a_outr and b_outr.
REQ-020 valid_out high cycles 3..L+5 inclusive (L+3 cycles); DRAIN covers cycles L+1..L+5 with rd_en=0.
REQ-021 done=1 at cycle L+6 only (DONE state), then IDLE at L+7; busy high cycles 1..L+5.
REQ-022 len=0: no reads, valid_out never asserted, done pulses at cycle 1, FSM returns to IDLE at cycle 2.
REQ-023 ap_start while busy or in DONE is ignored; latched len/base_col unchanged.
REQ-024 ap_start asserted in the IDLE cycle immediately after DONE is accepted (back-to-back runs, no bubble beyond DONE).
REQ-025 a_rowr/b_rowr inputs are ignored in cycles not preceded by rd_en=1.

Reset
REQ-026 rst=1 at any edge, including mid-run: FSM to IDLE; all skew registers, a_out*, b_out* to 0; rd_en, rd_col, valid_out, busy, done to 0.
REQ-027 A run interrupted by reset produces no done pulse; ap_start coincident with rst is dropped.

Configuration
REQ-028 Macro FEEDER_PERF_EN: when defined, adds output perf_cycles (16 bits), cleared on accepted start, +1 each busy cycle, saturating at 16'hFFFF, holding after done, 0 on reset.
REQ-029 Without FEEDER_PERF_EN: port perf_cycles and its counter are absent; all other behaviour is identical.

Verification
REQ-030 L=4, base_col=0, a_row r column j = 10*r+j: a_out2 shows 20,21,22,23 at cycles 5..8, 0 at cycles 3,4,9,10; valid_out cycles 3..9; done at 10.
REQ-031 L=3, base_col=254: rd_col sequence 254,255,0; data streamed in that column order.
REQ-032 L=0: done at cycle 1, rd_en and valid_out never high.
REQ-033 ap_start re-pulsed at cycle 2 of an L=5 run: ignored, single done at cycle 11; new start at cycle 12 accepted.
REQ-034 rst asserted at cycle 4 of an L=8 run: next cycle all outputs 0, IDLE, no done; fresh L=2 run then completes with done at cycle 8 after its start.
REQ-035 FEEDER_PERF_EN defined, L=4: perf_cycles=9 after done, holds until next accepted start.
